mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sits between the pipeline's instruction-fetch port and data-memory port and the single shared RAM port.
- Serialises instruction reads, data reads and data writes onto that one RAM port.
- Holds each grant until the RAM reports completion, then returns a one-cycle hit to the requester that owned the grant.
- Provides the ihit/dhit handshake the fetch and memory stages use for PC enable and pipeline latching.

Parameters:
- TIMEOUT, default 16: cycles a grant may wait for ACCESS before it is abandoned; legal range 2..255.
- CNT_W, default 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address (word_t)
- iload  out  32  instruction read data
- ihit  out  1  instruction access complete, one-cycle pulse
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dload  out  32  data read data
- dhit  out  1  data access complete, one-cycle pulse
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR
- ram_err  out  1  one-cycle pulse on RAM ERROR or timeout

Behaviour:
- Clock and reset: single clock CLK; asynchronous active-low reset nRST.
- Reset state:
  - FSM=IDLE, counter=0.
  - All outputs 0: iload, dload, ihit, dhit, ramREN, ramWEN, ramaddr, ramstore, ram_err.
- FSM states: IDLE, IGRANT, DGRANT.
- In IDLE:
  - If (dREN|dWEN), go to DGRANT; else if iREN, go to IGRANT; else stay.
  - RAM enables are 0 in IDLE, so arbitration costs exactly one cycle.
- In IGRANT:
  - Drive ramREN=1, ramWEN=0, ramaddr=iaddr.
- In DGRANT:
  - Drive ramaddr=daddr and ramstore=dstore.
  - If dWEN=1: ramWEN=1, ramREN=0. If dREN=1 and dWEN=0: ramREN=1, ramWEN=0.
  - dWEN has priority when both dREN and dWEN are high.
- Completion: in a grant state, ramstate==ACCESS is completion.
  - Raise ihit (IGRANT) or dhit (DGRANT) combinationally that same cycle.
  - iload/dload = ramload that cycle; otherwise 0.
  - Next state is IDLE.
- Minimum latency: request to hit is 2 cycles with a zero-wait RAM (ACCESS on the first grant cycle).
  - Each BUSY cycle adds 1.
  - Back-to-back accesses from one requester have one IDLE cycle between hits.
- Requester drop: if the granted requester deasserts its enable(s) before ACCESS, abort to IDLE next cycle.
  - No hit is produced; ram_err is not raised.
- ERROR: ramstate==ERROR in a grant state pulses ram_err for 1 cycle; no hit; next state is IDLE.
- Timeout counter:
  - Clears on entry to a grant state and increments each grant cycle without ACCESS.
  - When the counter reaches TIMEOUT-1 without ACCESS, pulse ram_err and return to IDLE.
  - Counter saturates and never wraps.
- Address/data changes mid-grant: passed straight through to the RAM; the requester must hold them stable (protocol rule, not checked).
- Reset mid-grant: immediate return to the reset state; any in-flight access is dropped and no hit is issued.
- Hit masking: ihit and dhit are never high in the same cycle, and never high in IDLE.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined:
  - A 1-bit last_grant register (reset 0 = instruction) is updated on every completion.
  - In IDLE with both iREN and (dREN|dWEN) pending, grant the side NOT served last.
  - Guarantees fetch progress under a continuous data stream.
- Not defined: fixed data priority as described in Behaviour; no last_grant register exists.

Test Plan:
- Reset, then iREN=1, iaddr=0x0000_0040, RAM returns ACCESS on first grant cycle with ramload=0x2001_0005 -> ramREN=1, ramaddr=0x40 in cycle 1; ihit=1, iload=0x2001_0005 in cycle 1; dhit=0 throughout.
- iREN=1 and dWEN=1 same cycle, daddr=0x100, dstore=0xDEAD_BEEF, 2 BUSY then ACCESS -> DGRANT first; ramWEN=1, ramstore=0xDEADBEEF; dhit in cycle 3; IDLE cycle; then IGRANT; ihit in cycle 5.
- dREN=1, daddr=0x200, RAM held BUSY forever, TIMEOUT=16 -> ram_err one-cycle pulse after 15 grant cycles; no dhit; FSM returns to IDLE.
- dREN=1, ramstate=ERROR in second grant cycle -> ram_err=1 for one cycle; dhit=0; ramREN=0 the next cycle.
- iREN dropped after 1 BUSY cycle -> next cycle IDLE, ramREN=0, ihit never asserts; nRST pulsed low mid-DGRANT -> all outputs 0 asynchronously.
- With MEM_ARB_FAIR_EN: iREN and dREN both held high for 6 hits -> hits alternate dhit/ihit/dhit... after the first grant; without the macro -> all 6 hits are dhit.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/memory request ports, the arbiter and the shared RAM port.
// The master modport is the arbiter's view; slave is the requester/RAM side.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        ihit;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dhit;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_err;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter onto a single RAM port with hit pulses, error and timeout.
// Optional MEM_ARB_FAIR_EN: alternate grants when both sides are pending.
module mem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dreq;
    logic             access;
    logic             error;
    logic             expired;
    logic             leave;
    logic             pick_d;

`ifdef MEM_ARB_FAIR_EN
    logic last_grant;
    // Only break the tie toward fetch when data was the side served last.
    assign pick_d = dreq && !(bus.iREN && last_grant);
`else
    assign pick_d = dreq;
`endif

    assign dreq    = bus.dREN | bus.dWEN;
    assign access  = (bus.ramstate == RAM_ACCESS);
    assign error   = (bus.ramstate == RAM_ERROR);
    assign expired = (cnt == CNT_W'(TIMEOUT - 1));

    // Hits, read data and RAM controls follow the current state and live inputs,
    // so completion is visible in the same cycle the RAM reports ACCESS.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ihit     = 1'b0;
        bus.dhit     = 1'b0;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ram_err  = 1'b0;
        leave        = 1'b0;
        case (state)
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (!bus.iREN) begin
                    leave = 1'b1;
                end else if (access) begin
                    bus.ihit  = 1'b1;
                    bus.iload = bus.ramload;
                    leave     = 1'b1;
                end else if (error || expired) begin
                    bus.ram_err = 1'b1;
                    leave       = 1'b1;
                end
            end
            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (!dreq) begin
                    leave = 1'b1;
                end else if (access) begin
                    bus.dhit  = 1'b1;
                    bus.dload = bus.ramload;
                    leave     = 1'b1;
                end else if (error || expired) begin
                    bus.ram_err = 1'b1;
                    leave       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state <= DGRANT;
                        cnt   <= '0;
                    end else if (bus.iREN) begin
                        state <= IGRANT;
                        cnt   <= '0;
                    end
                end
                IGRANT, DGRANT: begin
                    if (leave) begin
                        state <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_FAIR_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant <= 1'b0;
        end else if (bus.ihit) begin
            last_grant <= 1'b0;
        end else if (bus.dhit) begin
            last_grant <= 1'b1;
        end
    end
`endif
endmodule
